// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Types and constants shared by the multicycle core blocks.
//   mem_arb_state_t : sequencing states of the unified memory port
//   mem_owner_t     : which requester currently owns the memory port
//   MEM_LATENCY_MAX : largest memory read latency the port sequencer supports
//   MEM_CNT_W       : width of a counter able to hold 0..MEM_LATENCY_MAX
// -----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } mem_owner_t;

    localparam int MEM_LATENCY_MAX = 4;
    localparam int MEM_CNT_W       = $clog2(MEM_LATENCY_MAX + 1);

    // Instruction fetches must be word aligned.
    function automatic logic is_word_aligned(input logic [1:0] byte_off);
        return (byte_off == 2'b00);
    endfunction

endpackage : core_pkg

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Sequences the single unified memory port between instruction fetch and
// data load/store. Every output is a register; the combinational process
// computes next-state and next-output values together, so each output
// changes on the same edge as the state it belongs to.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   fetch_req/fetch_addr  fetch request and byte address (pc)
//   fetch_ack             one-cycle pulse, instruction valid on mem_rd (inst_en)
//   fetch_misaligned      one-cycle pulse, fetch_addr[1:0] != 0, no access made
//   data_req/data_we      load/store request, 1 = store
//   data_addr/wd/wmask    data byte address, store data, store byte mask
//   data_ack              one-cycle pulse, load data valid / store committed
//   busy                  high in every state except IDLE
//   mem_addr/wd/wmask     registered memory address, write data, byte mask
//   mem_we/mem_re         registered write / read enables
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int LATENCY = 1,   // read latency, mem_re sampled -> mem_rd valid (1..4)
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic              fetch_misaligned,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wd,
    input  logic [3:0]        data_wmask,
    output logic              data_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic [3:0]        mem_wmask,
    output logic              mem_we,
    output logic              mem_re
);

    import core_pkg::*;

    // -------------------------------------------------------------------------
    // State and bookkeeping registers
    // -------------------------------------------------------------------------
    mem_arb_state_t         r_state;
    mem_owner_t             r_owner;        // requester being / last served
    logic                   r_misaligned;   // current fetch was rejected
    logic                   r_is_store;     // current access is a store
    logic                   r_mask_last;    // first IDLE cycle after RESP
    logic [MEM_CNT_W-1:0]   r_wait_cnt;

    // Registered outputs
    logic                   r_fetch_ack;
    logic                   r_fetch_mis;
    logic                   r_data_ack;
    logic                   r_busy;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [31:0]            r_mem_wd;
    logic [3:0]             r_mem_wmask;
    logic                   r_mem_we;
    logic                   r_mem_re;

    // Next-state / next-output values
    mem_arb_state_t         w_next_state;
    mem_owner_t             w_owner;
    logic                   w_misaligned;
    logic                   w_is_store;
    logic                   w_fetch_ack;
    logic                   w_fetch_mis;
    logic                   w_data_ack;
    logic                   w_busy;
    logic [ADDR_W-1:0]      w_mem_addr;
    logic [31:0]            w_mem_wd;
    logic [3:0]             w_mem_wmask;
    logic                   w_mem_we;
    logic                   w_mem_re;

    // Request qualification. The requester just served may still hold its
    // req high during the first IDLE cycle after RESP, so it is ignored
    // there; the other requester is not, which lets data -> fetch run
    // back-to-back.
    logic                   w_data_ok;
    logic                   w_fetch_ok;

    assign w_data_ok  = data_req  && !(r_mask_last && (r_owner == OWN_DATA));
    assign w_fetch_ok = fetch_req && !(r_mask_last && (r_owner == OWN_FETCH));

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        w_next_state = r_state;
        w_owner      = r_owner;
        w_misaligned = r_misaligned;
        w_is_store   = r_is_store;
        w_mem_addr   = r_mem_addr;
        w_mem_wd     = r_mem_wd;
        w_mem_wmask  = '0;
        w_mem_we     = 1'b0;
        w_mem_re     = 1'b0;

        unique case (r_state)
            IDLE: begin
                // Data wins: a pending data access belongs to the
                // instruction already in flight.
                if (w_data_ok) begin
                    w_next_state = ISSUE;
                    w_owner      = OWN_DATA;
                    w_misaligned = 1'b0;
                    w_is_store   = data_we;
                    w_mem_addr   = data_addr;
                    w_mem_wd     = data_wd;
                    w_mem_wmask  = data_we ? data_wmask : 4'b0000;
                    w_mem_we     = data_we;
                    w_mem_re     = ~data_we;
                end else if (w_fetch_ok) begin
                    w_owner    = OWN_FETCH;
                    w_is_store = 1'b0;
                    if (is_word_aligned(fetch_addr[1:0])) begin
                        w_next_state = ISSUE;
                        w_misaligned = 1'b0;
                        w_mem_addr   = {fetch_addr[ADDR_W-1:2], 2'b00};
                        w_mem_re     = 1'b1;
                    end else begin
                        // Rejected fetch: no memory access, report at once.
                        w_next_state = RESP;
                        w_misaligned = 1'b1;
                    end
                end
            end

            ISSUE: begin
                if (r_is_store || (LATENCY <= 1)) begin
                    w_next_state = RESP;
                end else begin
                    w_next_state = WAIT;
                end
            end

            WAIT: begin
                if (r_wait_cnt <= MEM_CNT_W'(1)) begin
                    w_next_state = RESP;
                end
            end

            RESP: begin
                w_next_state = IDLE;
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Acks are registered alongside the state, so they are high exactly
        // while the FSM sits in RESP.
        w_busy      = (w_next_state != IDLE);
        w_fetch_ack = (w_next_state == RESP) && (w_owner == OWN_FETCH) && !w_misaligned;
        w_fetch_mis = (w_next_state == RESP) && (w_owner == OWN_FETCH) &&  w_misaligned;
        w_data_ack  = (w_next_state == RESP) && (w_owner == OWN_DATA);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= OWN_FETCH;
            r_misaligned <= 1'b0;
            r_is_store   <= 1'b0;
            r_mask_last  <= 1'b0;
            r_fetch_ack  <= 1'b0;
            r_fetch_mis  <= 1'b0;
            r_data_ack   <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wd     <= '0;
            r_mem_wmask  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_owner      <= w_owner;
            r_misaligned <= w_misaligned;
            r_is_store   <= w_is_store;
            r_mask_last  <= (r_state == RESP);
            r_fetch_ack  <= w_fetch_ack;
            r_fetch_mis  <= w_fetch_mis;
            r_data_ack   <= w_data_ack;
            r_busy       <= w_busy;
            r_mem_addr   <= w_mem_addr;
            r_mem_wd     <= w_mem_wd;
            r_mem_wmask  <= w_mem_wmask;
            r_mem_we     <= w_mem_we;
            r_mem_re     <= w_mem_re;
        end
    end

    // -------------------------------------------------------------------------
    // WAIT down-counter: loaded with LATENCY-1 on the ISSUE -> WAIT edge and
    // decremented each WAIT cycle; WAIT exits when it would reach zero, so
    // the FSM spends exactly LATENCY-1 cycles there.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ISSUE) && (w_next_state == WAIT)) begin
            r_wait_cnt <= MEM_CNT_W'(LATENCY - 1);
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt - MEM_CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign fetch_ack        = r_fetch_ack;
    assign fetch_misaligned = r_fetch_mis;
    assign data_ack         = r_data_ack;
    assign busy             = r_busy;
    assign mem_addr         = r_mem_addr;
    assign mem_wd           = r_mem_wd;
    assign mem_wmask        = r_mem_wmask;
    assign mem_we           = r_mem_we;
    assign mem_re           = r_mem_re;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Three arbiters (LATENCY = 1, 3, 4) share one stimulus stream. A
// transaction-level reference model per lane predicts every output each
// cycle from the access rules: an accepted access lasts a fixed number of
// cycles (read 1+LATENCY, store 2, misaligned fetch 1), the enables pulse
// in its first cycle, the ack in its last, and the served requester is
// ignored for one idle cycle afterwards.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int N = 3;

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wd = '0;
    logic [3:0]  data_wmask = '0;

    logic        fa    [N];
    logic        fm    [N];
    logic        da    [N];
    logic        bsy   [N];
    logic        mre   [N];
    logic        mwe   [N];
    logic [31:0] maddr [N];
    logic [31:0] mwd   [N];
    logic [3:0]  mwm   [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_lane
        mem_port_arbiter #(
            .LATENCY (lat_of(g)),
            .ADDR_W  (32)
        ) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .fetch_req        (fetch_req),
            .fetch_addr       (fetch_addr),
            .fetch_ack        (fa[g]),
            .fetch_misaligned (fm[g]),
            .data_req         (data_req),
            .data_we          (data_we),
            .data_addr        (data_addr),
            .data_wd          (data_wd),
            .data_wmask       (data_wmask),
            .data_ack         (da[g]),
            .busy             (bsy[g]),
            .mem_addr         (maddr[g]),
            .mem_wd           (mwd[g]),
            .mem_wmask        (mwm[g]),
            .mem_we           (mwe[g]),
            .mem_re           (mre[g])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model (one per lane)
    // m_k: cycle index inside the current access, 1..m_d; 0 when idle.
    // ------------------------------------------------------------------
    int          m_k        [N];
    int          m_d        [N];
    bit          m_own_data [N];
    bit          m_mis      [N];
    bit          m_store    [N];
    bit          m_mask_v   [N];
    bit          m_mask_dat [N];
    logic [31:0] e_addr     [N];
    logic [31:0] e_wd       [N];
    logic [3:0]  e_wmask    [N];

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                m_k[i]      = 0;
                m_mask_v[i] = 0;
                e_addr[i]   = '0;
                e_wd[i]     = '0;
            end else if (m_k[i] == 0) begin
                bit d_ok;
                bit f_ok;
                d_ok = data_req  && !(m_mask_v[i] &&  m_mask_dat[i]);
                f_ok = fetch_req && !(m_mask_v[i] && !m_mask_dat[i]);
                m_mask_v[i] = 0;
                if (d_ok) begin
                    m_own_data[i] = 1;
                    m_store[i]    = data_we;
                    m_mis[i]      = 0;
                    m_d[i]        = data_we ? 2 : 1 + lat_of(i);
                    e_addr[i]     = data_addr;
                    e_wd[i]       = data_wd;
                    e_wmask[i]    = data_wmask;
                    m_k[i]        = 1;
                end else if (f_ok) begin
                    m_own_data[i] = 0;
                    m_store[i]    = 0;
                    m_mis[i]      = (fetch_addr % 4) != 0;
                    m_d[i]        = m_mis[i] ? 1 : 1 + lat_of(i);
                    if (!m_mis[i]) e_addr[i] = fetch_addr - (fetch_addr % 4);
                    m_k[i]        = 1;
                end
            end else if (m_k[i] == m_d[i]) begin
                m_k[i]        = 0;
                m_mask_v[i]   = 1;
                m_mask_dat[i] = m_own_data[i];
            end else begin
                m_k[i]++;
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < N; i++) begin
            bit first;
            bit at_ack;
            first  = (m_k[i] == 1);
            at_ack = (m_k[i] != 0) && (m_k[i] == m_d[i]);
            check($sformatf("L%0d busy", lat_of(i)),      32'(bsy[i]), 32'(m_k[i] != 0));
            check($sformatf("L%0d mem_re", lat_of(i)),    32'(mre[i]), 32'(first && !m_mis[i] && !m_store[i]));
            check($sformatf("L%0d mem_we", lat_of(i)),    32'(mwe[i]), 32'(first && m_store[i]));
            check($sformatf("L%0d mem_wmask", lat_of(i)), 32'(mwm[i]), 32'((first && m_store[i]) ? e_wmask[i] : 4'h0));
            check($sformatf("L%0d mem_addr", lat_of(i)),  maddr[i],    e_addr[i]);
            check($sformatf("L%0d mem_wd", lat_of(i)),    mwd[i],      e_wd[i]);
            check($sformatf("L%0d fetch_ack", lat_of(i)), 32'(fa[i]),  32'(at_ack && !m_own_data[i] && !m_mis[i]));
            check($sformatf("L%0d fetch_mis", lat_of(i)), 32'(fm[i]),  32'(at_ack && !m_own_data[i] &&  m_mis[i]));
            check($sformatf("L%0d data_ack", lat_of(i)),  32'(da[i]),  32'(at_ack &&  m_own_data[i]));
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_k[i] = 0; m_d[i] = 0; m_own_data[i] = 0; m_mis[i] = 0; m_store[i] = 0;
            m_mask_v[i] = 0; m_mask_dat[i] = 0; e_addr[i] = '0; e_wd[i] = '0; e_wmask[i] = '0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check_outputs();
        end
    end

    // ------------------------------------------------------------------
    // Directed requester helpers (follow the acks of lane ld)
    // ------------------------------------------------------------------
    task automatic serve_fetch(input int ld, input logic [31:0] a);
        bit done;
        done       = 0;
        fetch_addr = a;
        fetch_req  = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (fa[ld] || fm[ld]) done = 1;
        end
        fetch_req = 1'b0;
        if (!done) check("fetch ack timeout", 32'(0), 32'(1));
    endtask

    task automatic serve_data(input int ld, input bit we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] wm);
        bit done;
        done       = 0;
        data_we    = we;
        data_addr  = a;
        data_wd    = wd;
        data_wmask = wm;
        data_req   = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (da[ld]) done = 1;
        end
        data_req = 1'b0;
        if (!done) check("data ack timeout", 32'(0), 32'(1));
    endtask

    // Both requests raised together: data must be acked first, then fetch.
    task automatic serve_both(input int ld, input logic [31:0] fa_addr, input logic [31:0] da_addr);
        bit d_done;
        bit f_done;
        bit order_ok;
        d_done     = 0;
        f_done     = 0;
        order_ok   = 1;
        fetch_addr = fa_addr;
        data_we    = 1'b0;
        data_addr  = da_addr;
        fetch_req  = 1'b1;
        data_req   = 1'b1;
        for (int c = 0; c < 30 && !f_done; c++) begin
            @(negedge clk);
            if (da[ld]) begin d_done = 1; data_req = 1'b0; end
            if (fa[ld]) begin f_done = 1; fetch_req = 1'b0; if (!d_done) order_ok = 0; end
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        check("simultaneous data first", 32'(order_ok), 32'(1));
        check("simultaneous both served", 32'(d_done && f_done), 32'(1));
    endtask

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    initial begin
        bit          f_on;
        bit          d_on;
        bit          f_lin;
        bit          d_lin;
        logic [31:0] a;

        repeat (2) @(negedge clk);
        check("reset busy",     32'(bsy[0]), 32'(0));
        check("reset mem_addr", maddr[2],    32'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed transactions, lead lane LATENCY=1 (then idle long enough
        // for the LATENCY=4 lane to drain).
        serve_fetch(0, 32'h0000_0100);                       repeat (8) @(negedge clk);
        serve_data(1, 1'b0, 32'h0000_2004, 32'h0, 4'h0);     repeat (8) @(negedge clk);
        serve_data(0, 1'b1, 32'h0000_2008, 32'hDEAD_BEEF, 4'b0011); repeat (8) @(negedge clk);
        serve_both(0, 32'h0000_0104, 32'h0000_3000);         repeat (8) @(negedge clk);
        serve_fetch(0, 32'h0000_0102);                       repeat (8) @(negedge clk);

        // Reset while the LATENCY=4 lane sits in WAIT.
        fetch_addr = 32'h0000_0200;
        fetch_req  = 1'b1;
        @(negedge clk);           // ISSUE
        fetch_req  = 1'b0;
        @(negedge clk);           // first WAIT cycle
        check("pre-reset L4 busy", 32'(bsy[2]), 32'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("post-reset L4 busy",     32'(bsy[2]), 32'(0));
        check("post-reset L4 mem_addr", maddr[2],    32'(0));
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Randomized phases: requesters follow one lead lane's acks.
        for (int ld = 0; ld < N; ld++) begin
            f_on = 0; d_on = 0; f_lin = 0; d_lin = 0;
            for (int cyc = 0; cyc < 1500; cyc++) begin
                @(negedge clk);
                if (!rst_n) begin
                    rst_n = 1'b1;
                end else if ($urandom_range(199) == 0) begin
                    rst_n = 1'b0;
                    f_on = 0; d_on = 0; f_lin = 0; d_lin = 0;
                end

                if (fa[ld] || fm[ld]) begin
                    f_on  = 0;
                    f_lin = $urandom_range(1) == 1;
                end else begin
                    f_lin = 0;
                    if (!f_on && $urandom_range(3) == 0) begin
                        a = $urandom;
                        if ($urandom_range(3) != 0) a[1:0] = 2'b00;
                        fetch_addr = a;
                        f_on = 1;
                    end else if (f_on && $urandom_range(99) == 0) begin
                        f_on = 0;
                    end
                end

                if (da[ld]) begin
                    d_on  = 0;
                    d_lin = $urandom_range(1) == 1;
                end else begin
                    d_lin = 0;
                    if (!d_on && $urandom_range(4) == 0) begin
                        data_we    = $urandom_range(1) == 1;
                        data_addr  = $urandom;
                        data_wd    = $urandom;
                        data_wmask = 4'($urandom_range(15));
                        d_on = 1;
                    end else if (d_on && $urandom_range(99) == 0) begin
                        d_on = 0;
                    end
                end

                fetch_req = f_on || f_lin;
                data_req  = d_on || d_lin;
            end
            fetch_req = 1'b0;
            data_req  = 1'b0;
            rst_n     = 1'b1;
            repeat (8) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter
